// File: rtl/cp0_ext.sv
// System-control coprocessor: Status/Cause/EPC/BadVAddr/Count/Compare,
// timer interrupt, synchronised hardware IRQ lines and a 3-level KU/IE stack.
module cp0_ext #(
    parameter int unsigned NUM_IRQ   = 5,
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pause,
    input  logic               mtc0_wen,
    input  logic [4:0]         mtc0_addr,
    input  logic [31:0]        mtc0_data,
    input  logic [4:0]         mfc0_addr,
    output logic [31:0]        mfc0_data,
    input  logic               exc_req,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        exc_pc,
    input  logic               exc_bd,
    input  logic               exc_badva_valid,
    input  logic [31:0]        exc_badva,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               int_req,
    output logic [31:0]        status_out,
    output logic [31:0]        epc_out
);

    localparam logic [4:0] REG_BADVA   = 5'd8;
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    localparam logic [4:0] PRESC_LAST  = 5'(COUNT_DIV - 1);

    logic [7:0]         im_q,      im_d;
    logic [5:0]         mode_q,    mode_d;
    logic               bd_q,      bd_d;
    logic               ti_q,      ti_d;
    logic [1:0]         sw_q,      sw_d;
    logic [4:0]         exccode_q, exccode_d;
    logic [31:0]        epc_q,     epc_d;
    logic [31:0]        badva_q,   badva_d;
    logic [31:0]        count_q,   count_d;
    logic [31:0]        compare_q, compare_d;
    logic [4:0]         presc_q,   presc_d;
    logic [NUM_IRQ-1:0] sync1_q,   sync2_q;

    logic        wr_ok, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        exc_take, eret_take;
    logic        presc_wrap;
    logic [31:0] count_inc;
    logic [4:0]  ip_hw;
    logic [7:0]  ip;
    logic [31:0] status_val, cause_val;

    assign wr_ok      = mtc0_wen & ~pause;
    assign wr_count   = wr_ok && (mtc0_addr == REG_COUNT);
    assign wr_compare = wr_ok && (mtc0_addr == REG_COMPARE);
    assign wr_status  = wr_ok && (mtc0_addr == REG_STATUS);
    assign wr_cause   = wr_ok && (mtc0_addr == REG_CAUSE);
    assign wr_epc     = wr_ok && (mtc0_addr == REG_EPC);

    assign exc_take   = exc_req & ~pause;
    assign eret_take  = eret & ~exc_req & ~pause;

    assign presc_wrap = (presc_q == PRESC_LAST);
    assign count_inc  = count_q + 32'd1;

    // Timer keeps running through pause; only MTC0 is gated by it.
    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        ti_d    = ti_q;
        if (wr_count) begin
            count_d = mtc0_data;
            presc_d = '0;
        end else if (presc_wrap) begin
            count_d = count_inc;
            presc_d = '0;
        end else begin
            presc_d = presc_q + 5'd1;
        end
        if (wr_compare) begin
            ti_d = 1'b0;
        end else if (presc_wrap && !wr_count && (count_inc == compare_q)) begin
            ti_d = 1'b1;
        end
    end

    always_comb begin
        compare_d = compare_q;
        im_d      = im_q;
        mode_d    = mode_q;
        sw_d      = sw_q;
        epc_d     = epc_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        badva_d   = badva_q;

        if (wr_compare) compare_d = mtc0_data;
        if (wr_status) begin
            im_d   = mtc0_data[15:8];
            mode_d = mtc0_data[5:0];
        end
        if (wr_cause) sw_d = mtc0_data[9:8];
        if (wr_epc)   epc_d = mtc0_data;

        // Exception entry wins over an MTC0 to the same field.
        if (exc_take) begin
            mode_d    = {mode_q[3:0], 2'b00};
            epc_d     = exc_bd ? (exc_pc - 32'd4) : exc_pc;
            bd_d      = exc_bd;
            exccode_d = exc_code;
            if (exc_badva_valid) badva_d = exc_badva;
        end else if (eret_take) begin
            mode_d = {mode_q[5:4], mode_q[5:2]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q      <= '0;
            mode_q    <= '0;
            bd_q      <= 1'b0;
            ti_q      <= 1'b0;
            sw_q      <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
            badva_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            presc_q   <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            im_q      <= im_d;
            mode_q    <= mode_d;
            bd_q      <= bd_d;
            ti_q      <= ti_d;
            sw_q      <= sw_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
            badva_q   <= badva_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            presc_q   <= presc_d;
            sync1_q   <= irq_in;
            sync2_q   <= sync1_q;
        end
    end

    always_comb begin
        ip_hw              = '0;
        ip_hw[NUM_IRQ-1:0] = sync2_q;
    end

    assign ip         = {ti_q, ip_hw, sw_q};
    assign status_val = {16'b0, im_q, 2'b00, mode_q};
    assign cause_val  = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b00};

    always_comb begin
        case (mfc0_addr)
            REG_BADVA:   mfc0_data = badva_q;
            REG_COUNT:   mfc0_data = count_q;
            REG_COMPARE: mfc0_data = compare_q;
            REG_STATUS:  mfc0_data = status_val;
            REG_CAUSE:   mfc0_data = cause_val;
            REG_EPC:     mfc0_data = epc_q;
            default:     mfc0_data = '0;
        endcase
    end

    assign int_req    = mode_q[0] & (|(ip & im_q));
    assign status_out = status_val;
    assign epc_out    = epc_q;

endmodule
